// File: rtl/iommu_ddtw_if.sv
// Single-beat 64-bit read port between the DDT walker and memory.
// The walker drives the request side, memory answers with grant and data.
interface iommu_ddtw_if #(
    parameter int ADDR_WIDTH = 56
);
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [63:0]           mem_rdata;
    logic                  mem_err;

    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err
    );
endinterface

// File: rtl/iommu_ddtw.sv
// Device Directory Table walker: resolves a device_id to its 32-byte
// device context through a 1/2/3-level DDT, feeding the DDTC or a fault.
module iommu_ddtw #(
    parameter int ADDR_WIDTH = 56
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          init_i,
    input  logic [23:0]   did_i,
    input  logic [3:0]    ddtp_mode_i,
    input  logic [43:0]   ddtp_ppn_i,
    input  logic          flush_i,
    iommu_ddtw_if.master  bus,
    output logic          busy_o,
    output logic          ddtc_update_o,
    output logic [23:0]   ddtc_did_o,
    output logic [255:0]  ddtc_content_o,
    output logic          done_o,
    output logic          error_o,
    output logic [11:0]   cause_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_NL_REQ, S_NL_WAIT, S_LF_REQ, S_LF_WAIT, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [23:0]           did_q, did_d;
    logic [3:0]            mode_q, mode_d;
    logic [43:0]           ppn_q, ppn_d;
    logic [1:0]            level_q, level_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [1:0]            beat_q, beat_d;
    logic [255:0]          content_q, content_d;
    logic                  err_q, err_d;
    logic [11:0]           cause_q, cause_d;
    logic                  flush_q, flush_d;

    logic [11:0] chk_cause, nl_cause, tc_cause;
    logic [11:0] nl_off, lf_off;
    logic [55:0] root_full, next_full;
    logic        busy;

    // Fault classification for the mode/range check, non-leaf and leaf entries
    always_comb begin
        chk_cause = 12'd0;
        if (mode_q < 4'd2 || mode_q > 4'd4)
            chk_cause = 12'd259;
        else if (mode_q == 4'd2 && did_q[23:7] != 17'd0)
            chk_cause = 12'd260;
        else if (mode_q == 4'd3 && did_q[23:16] != 8'd0)
            chk_cause = 12'd260;

        nl_cause = 12'd0;
        if (bus.mem_err)
            nl_cause = 12'd257;
        else if (!bus.mem_rdata[0])
            nl_cause = 12'd258;
        else if (bus.mem_rdata[63:54] != 10'd0 || bus.mem_rdata[9:1] != 9'd0)
            nl_cause = 12'd259;

        // tc landed in beat 0, so it is already stored when beat 3 arrives
        tc_cause = 12'd0;
        if (!content_q[0])
            tc_cause = 12'd258;
        else if (content_q[63:32] != 32'd0)
            tc_cause = 12'd259;
    end

    // Table offsets: DDI2/DDI1 pick an 8-byte pointer, DDI0 a 32-byte DC
    always_comb begin
        nl_off    = (level_q == 2'd2) ? {1'b0, did_q[23:16], 3'b0}
                                      : {did_q[15:7], 3'b0};
        lf_off    = {did_q[6:0], 5'b0} + {7'b0, beat_q, 3'b0};
        root_full = {ppn_q, 12'h000};
        next_full = {bus.mem_rdata[53:10], 12'h000};
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (init_i) state_d = S_CHECK;
            S_CHECK: begin
                if (chk_cause != 12'd0)  state_d = S_DONE;
                else if (mode_q == 4'd2) state_d = S_LF_REQ;
                else                     state_d = S_NL_REQ;
            end
            S_NL_REQ:  if (bus.mem_gnt) state_d = S_NL_WAIT;
            S_NL_WAIT: begin
                if (bus.mem_rvalid) begin
                    if (nl_cause != 12'd0)  state_d = S_DONE;
                    else if (level_q == 2'd1) state_d = S_LF_REQ;
                    else                    state_d = S_NL_REQ;
                end
            end
            S_LF_REQ:  if (bus.mem_gnt) state_d = S_LF_WAIT;
            S_LF_WAIT: begin
                if (bus.mem_rvalid) begin
                    if (bus.mem_err || beat_q == 2'd3) state_d = S_DONE;
                    else                               state_d = S_LF_REQ;
                end
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output decode; address is only driven while a request is up
    always_comb begin
        busy          = (state_q != S_IDLE);
        busy_o        = busy;
        bus.mem_req   = (state_q == S_NL_REQ) || (state_q == S_LF_REQ);
        bus.mem_addr  = '0;
        if (state_q == S_NL_REQ)
            bus.mem_addr = base_q + ADDR_WIDTH'(nl_off);
        else if (state_q == S_LF_REQ)
            bus.mem_addr = base_q + ADDR_WIDTH'(lf_off);
        done_o         = (state_q == S_DONE);
        error_o        = done_o && err_q;
        cause_o        = error_o ? cause_q : 12'd0;
        ddtc_update_o  = done_o && !err_q && !flush_q;
        ddtc_did_o     = ddtc_update_o ? did_q : 24'd0;
        ddtc_content_o = content_q;
    end

    // Walk datapath next-state: latched request, cursor, DC and fault
    always_comb begin
        did_d     = did_q;
        mode_d    = mode_q;
        ppn_d     = ppn_q;
        level_d   = level_q;
        base_d    = base_q;
        beat_d    = beat_q;
        content_d = content_q;
        err_d     = err_q;
        cause_d   = cause_q;
        flush_d   = flush_q;
        // An invalidation during the walk makes the fetched DC unsafe to cache
        if (state_q == S_DONE)   flush_d = 1'b0;
        else if (flush_i && busy) flush_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (init_i) begin
                    did_d   = did_i;
                    mode_d  = ddtp_mode_i;
                    ppn_d   = ddtp_ppn_i;
                    err_d   = 1'b0;
                    cause_d = 12'd0;
                end
            end
            S_CHECK: begin
                level_d = 2'(mode_q - 4'd2);
                base_d  = ADDR_WIDTH'(root_full);
                beat_d  = 2'd0;
                if (chk_cause != 12'd0) begin
                    err_d   = 1'b1;
                    cause_d = chk_cause;
                end
            end
            S_NL_WAIT: begin
                if (bus.mem_rvalid) begin
                    if (nl_cause != 12'd0) begin
                        err_d   = 1'b1;
                        cause_d = nl_cause;
                    end else begin
                        base_d  = ADDR_WIDTH'(next_full);
                        level_d = level_q - 2'd1;
                    end
                end
            end
            S_LF_WAIT: begin
                if (bus.mem_rvalid) begin
                    if (bus.mem_err) begin
                        err_d   = 1'b1;
                        cause_d = 12'd257;
                    end else begin
                        content_d[{beat_q, 6'b0} +: 64] = bus.mem_rdata;
                        beat_d = beat_q + 2'd1;
                        if (beat_q == 2'd3 && tc_cause != 12'd0) begin
                            err_d   = 1'b1;
                            cause_d = tc_cause;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Walk datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            did_q     <= '0;
            mode_q    <= '0;
            ppn_q     <= '0;
            level_q   <= '0;
            base_q    <= '0;
            beat_q    <= '0;
            content_q <= '0;
            err_q     <= 1'b0;
            cause_q   <= '0;
            flush_q   <= 1'b0;
        end else begin
            did_q     <= did_d;
            mode_q    <= mode_d;
            ppn_q     <= ppn_d;
            level_q   <= level_d;
            base_q    <= base_d;
            beat_q    <= beat_d;
            content_q <= content_d;
            err_q     <= err_d;
            cause_q   <= cause_d;
            flush_q   <= flush_d;
        end
    end
endmodule

// File: tb/tb_iommu_ddtw.sv
// Bench for the DDT walker: memory image model with grant backpressure
// and error injection, table of directed walks, flush/reset sequences.
module tb_iommu_ddtw;
    localparam int AW = 56;

    typedef struct {
        string          nm;
        logic [3:0]     mode;
        logic [43:0]    ppn;
        logic [23:0]    did;
        logic [63:0]    nl_a;
        logic [63:0]    nl_b;
        logic [255:0]   dc;
        int             err_req;
        int             gdly;
        int             flush_at;
        int             poke_at;
        logic           exp_err;
        logic [11:0]    cause;
        int             nreq;
        logic [AW-1:0]  addr0;
        int             lat;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          init_i = 1'b0;
    logic [23:0]   did_i = '0;
    logic [3:0]    mode_i = '0;
    logic [43:0]   ppn_i = '0;
    logic          flush_i = 1'b0;
    logic          busy_o, ddtc_update_o, done_o, error_o;
    logic [23:0]   ddtc_did_o;
    logic [255:0]  ddtc_content_o;
    logic [11:0]   cause_o;

    iommu_ddtw_if #(.ADDR_WIDTH(AW)) bus ();

    iommu_ddtw #(.ADDR_WIDTH(AW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .init_i         (init_i),
        .did_i          (did_i),
        .ddtp_mode_i    (mode_i),
        .ddtp_ppn_i     (ppn_i),
        .flush_i        (flush_i),
        .bus            (bus.master),
        .busy_o         (busy_o),
        .ddtc_update_o  (ddtc_update_o),
        .ddtc_did_o     (ddtc_did_o),
        .ddtc_content_o (ddtc_content_o),
        .done_o         (done_o),
        .error_o        (error_o),
        .cause_o        (cause_o)
    );

    always #5 clk = ~clk;

    // Memory model
    logic [63:0]   mem [logic [AW-1:0]];
    logic [AW-1:0] gaddr [$];
    int            gnt_dly = 0;
    int            err_req = -1;
    int            wcnt = 0;
    int            nreq = 0;
    int            moved = 0;
    logic          hold_v = 1'b0;
    logic [AW-1:0] hold_a = '0;
    logic          rv = 1'b0;
    logic          re = 1'b0;
    logic [63:0]   rd = '0;

    assign bus.mem_gnt    = bus.mem_req && (wcnt >= gnt_dly);
    assign bus.mem_rvalid = rv;
    assign bus.mem_rdata  = rd;
    assign bus.mem_err    = re;

    always @(posedge clk) begin
        rv <= 1'b0;
        re <= 1'b0;
        if (hold_v && rst_ni && (!bus.mem_req || bus.mem_addr != hold_a))
            moved <= moved + 1;
        hold_v <= bus.mem_req && !bus.mem_gnt;
        hold_a <= bus.mem_addr;
        if (bus.mem_req && bus.mem_gnt) begin
            rv   <= 1'b1;
            rd   <= mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 64'h0;
            re   <= (nreq == err_req);
            nreq <= nreq + 1;
            wcnt <= 0;
            gaddr.push_back(bus.mem_addr);
        end else if (bus.mem_req) begin
            wcnt <= wcnt + 1;
        end
    end

    // Output monitor
    int            done_cnt = 0;
    int            upd_cnt = 0;
    logic [23:0]   upd_did = '0;
    logic [255:0]  upd_dc = '0;

    always @(negedge clk) begin
        if (done_o) done_cnt++;
        if (ddtc_update_o) begin
            upd_cnt++;
            upd_did = ddtc_did_o;
            upd_dc  = ddtc_content_o;
        end
    end

    int   errs = 0;
    int   checks = 0;
    vec_t vq [$];

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic [3:0] mode,
                       input logic [43:0] ppn, input logic [23:0] did,
                       input logic [63:0] nl_a, input logic [63:0] nl_b,
                       input logic [255:0] dc, input int err_rq,
                       input int gdly, input int flush_at, input int poke_at,
                       input logic exp_err, input logic [11:0] cause,
                       input int nr, input logic [AW-1:0] addr0,
                       input int lat);
        vec_t v;
        v.nm = nm; v.mode = mode; v.ppn = ppn; v.did = did;
        v.nl_a = nl_a; v.nl_b = nl_b; v.dc = dc;
        v.err_req = err_rq; v.gdly = gdly;
        v.flush_at = flush_at; v.poke_at = poke_at;
        v.exp_err = exp_err; v.cause = cause; v.nreq = nr;
        v.addr0 = addr0; v.lat = lat;
        vq.push_back(v);
    endtask

    // Lay out the tables this walk will touch
    task automatic setup_mem(input vec_t v);
        logic [AW-1:0] b;
        mem.delete();
        b = AW'({v.ppn, 12'h000});
        if (v.mode == 4'd4) begin
            mem[b + AW'({v.did[23:16], 3'b0})] = v.nl_a;
            b = AW'({v.nl_a[53:10], 12'h000});
            mem[b + AW'({v.did[15:7], 3'b0})] = v.nl_b;
            b = AW'({v.nl_b[53:10], 12'h000});
        end else if (v.mode == 4'd3) begin
            mem[b + AW'({v.did[15:7], 3'b0})] = v.nl_a;
            b = AW'({v.nl_a[53:10], 12'h000});
        end
        for (int k = 0; k < 4; k++)
            mem[b + AW'({v.did[6:0], 5'b0}) + AW'(k * 8)] = v.dc[k*64 +: 64];
    endtask

    task automatic run_vec(input vec_t v);
        int n, d0, u0, r0, m0, q0;
        logic got, ez, upd_exp;
        logic [11:0] cz;
        setup_mem(v);
        @(negedge clk);
        gnt_dly = v.gdly;
        err_req = (v.err_req < 0) ? -1 : nreq + v.err_req;
        d0 = done_cnt; u0 = upd_cnt; r0 = nreq; m0 = moved;
        q0 = gaddr.size();
        mode_i = v.mode; ppn_i = v.ppn; did_i = v.did;
        init_i = 1'b1;
        @(negedge clk);
        init_i = 1'b0;
        n = 1; got = 1'b0; ez = 1'b0; cz = '0;
        while (n < 300) begin
            flush_i = (n == v.flush_at);
            if (n == v.poke_at) begin
                init_i = 1'b1; did_i = 24'h5; mode_i = 4'd2;
            end else begin
                init_i = 1'b0;
            end
            if (done_o) begin
                got = 1'b1; ez = error_o; cz = cause_o;
                break;
            end
            @(negedge clk);
            n++;
        end
        flush_i = 1'b0;
        init_i  = 1'b0;
        repeat (2) @(negedge clk);
        upd_exp = !v.exp_err && (v.flush_at == 0);
        chk({v.nm, " done"}, 256'(got), 256'(1));
        chk({v.nm, " latency"}, 256'(n), 256'(v.lat));
        chk({v.nm, " error"}, 256'(ez), 256'(v.exp_err));
        if (v.exp_err) chk({v.nm, " cause"}, 256'(cz), 256'(v.cause));
        chk({v.nm, " nreq"}, 256'(nreq - r0), 256'(v.nreq));
        if (gaddr.size() > q0)
            chk({v.nm, " addr0"}, 256'(gaddr[q0]), 256'(v.addr0));
        chk({v.nm, " addr_stable"}, 256'(moved - m0), 256'(0));
        chk({v.nm, " done_pulses"}, 256'(done_cnt - d0), 256'(1));
        chk({v.nm, " updates"}, 256'(upd_cnt - u0), 256'(upd_exp));
        if (upd_exp) begin
            chk({v.nm, " did"}, 256'(upd_did), 256'(v.did));
            chk({v.nm, " dc"}, upd_dc, v.dc);
        end
    endtask

    localparam logic [63:0] NLA = 64'h40001;
    localparam logic [63:0] NLB = 64'h80001;

    initial begin
        int d0, u0;
        //  name      mode ppn        did        nl_a              nl_b  dc
        //  err gdly fl poke exp_err cause nreq addr0 lat
        add("lvl1", 4'd2, 44'h80000, 24'h000005, 64'h0, 64'h0,
            {64'h3333, 64'h2222, 64'h1111, 64'h1},
            -1, 0, 0, 0, 1'b0, 12'd0, 4, 56'h800000A0, 10);
        add("lvl3", 4'd4, 44'h80000, 24'h123467, NLA, NLB,
            {64'hA3, 64'hA2, 64'hA1, 64'h11},
            -1, 0, 0, 0, 1'b0, 12'd0, 6, 56'h80000090, 14);
        add("lvl2", 4'd3, 44'h01234, 24'h00ABCD, NLA, 64'h0,
            {64'hB3, 64'hB2, 64'hB1, 64'h80000001},
            -1, 0, 0, 0, 1'b0, 12'd0, 5, 56'h01234AB8, 12);
        add("nl_zero", 4'd4, 44'h80000, 24'h123467, 64'h0, NLB, 256'h1,
            -1, 0, 0, 0, 1'b1, 12'd258, 1, 56'h80000090, 4);
        add("nl_bit5", 4'd4, 44'h80000, 24'h123467, 64'h40021, NLB, 256'h1,
            -1, 0, 0, 0, 1'b1, 12'd259, 1, 56'h80000090, 4);
        add("nl_hi", 4'd3, 44'h01234, 24'h00ABCD, NLA | (64'h1 << 60), 64'h0,
            256'h1, -1, 0, 0, 0, 1'b1, 12'd259, 1, 56'h01234AB8, 4);
        add("nl_err", 4'd3, 44'h01234, 24'h00ABCD, NLA, 64'h0, 256'h1,
            0, 0, 0, 0, 1'b1, 12'd257, 1, 56'h01234AB8, 4);
        add("leaf_err", 4'd2, 44'h80000, 24'h000005, 64'h0, 64'h0, 256'h1,
            1, 0, 0, 0, 1'b1, 12'd257, 2, 56'h800000A0, 6);
        add("range1", 4'd2, 44'h80000, 24'h000080, 64'h0, 64'h0, 256'h1,
            -1, 0, 0, 0, 1'b1, 12'd260, 0, 56'h0, 2);
        add("range2", 4'd3, 44'h80000, 24'h010000, NLA, 64'h0, 256'h1,
            -1, 0, 0, 0, 1'b1, 12'd260, 0, 56'h0, 2);
        add("mode0", 4'd0, 44'h80000, 24'h000005, 64'h0, 64'h0, 256'h1,
            -1, 0, 0, 0, 1'b1, 12'd259, 0, 56'h0, 2);
        add("tc_v0", 4'd2, 44'h80000, 24'h000005, 64'h0, 64'h0,
            {64'h3, 64'h2, 64'h1, 64'h2},
            -1, 0, 0, 0, 1'b1, 12'd258, 4, 56'h800000A0, 10);
        add("tc_hi", 4'd2, 44'h80000, 24'h000005, 64'h0, 64'h0,
            {64'h3, 64'h2, 64'h1, 64'h1_00000001},
            -1, 0, 0, 0, 1'b1, 12'd259, 4, 56'h800000A0, 10);
        add("bp5", 4'd4, 44'h80000, 24'h123467, NLA, NLB,
            {64'hC3, 64'hC2, 64'hC1, 64'h7},
            -1, 5, 0, 3, 1'b0, 12'd0, 6, 56'h80000090, 44);
        add("flush", 4'd4, 44'h80000, 24'h123467, NLA, NLB,
            {64'hD3, 64'hD2, 64'hD1, 64'h1},
            -1, 0, 4, 0, 1'b0, 12'd0, 6, 56'h80000090, 14);
        add("after_flush", 4'd2, 44'h80000, 24'h000005, 64'h0, 64'h0,
            {64'hE3, 64'hE2, 64'hE1, 64'h1},
            -1, 0, 0, 0, 1'b0, 12'd0, 4, 56'h800000A0, 10);

        repeat (2) @(negedge clk);
        chk("rst busy", 256'(busy_o), 256'(0));
        chk("rst req", 256'(bus.mem_req), 256'(0));
        chk("rst addr", 256'(bus.mem_addr), 256'(0));
        chk("rst done", 256'(done_o), 256'(0));
        chk("rst update", 256'(ddtc_update_o), 256'(0));
        chk("rst content", ddtc_content_o, 256'(0));
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vq[i]) run_vec(vq[i]);

        // Reset in the middle of a 3-level walk
        setup_mem(vq[1]);
        @(negedge clk);
        gnt_dly = 0; err_req = -1;
        mode_i = vq[1].mode; ppn_i = vq[1].ppn; did_i = vq[1].did;
        init_i = 1'b1;
        @(negedge clk);
        init_i = 1'b0;
        repeat (4) @(negedge clk);
        rst_ni = 1'b0;
        #1;
        chk("midrst busy", 256'(busy_o), 256'(0));
        chk("midrst req", 256'(bus.mem_req), 256'(0));
        chk("midrst addr", 256'(bus.mem_addr), 256'(0));
        chk("midrst done", 256'(done_o), 256'(0));
        chk("midrst error", 256'(error_o), 256'(0));
        chk("midrst content", ddtc_content_o, 256'(0));
        d0 = done_cnt; u0 = upd_cnt;
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst no_done", 256'(done_cnt - d0), 256'(0));
        chk("midrst no_update", 256'(upd_cnt - u0), 256'(0));
        chk("midrst idle", 256'(busy_o), 256'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
